// File: rtl/kbd_event_queue_if.sv
// Scanner-side snapshot handshake and CPU-side event FIFO signals for
// kbd_event_queue. The master drives snapshots and pops; the slave is the queue.
interface kbd_event_queue_if #(
    parameter int ROWS = 9
);
    logic            scan_valid;
    logic            scan_ready;
    logic [3:0]      scan_col;
    logic [ROWS-1:0] scan_rows;
    logic            scan_frame_end;
    logic [7:0]      evt_data;
    logic            evt_valid;
    logic            evt_ready;
    logic [4:0]      evt_count;
    logic            overflow;
    logic            ovf_clear;
    logic            frame_irq;

    modport master (
        output scan_valid, scan_col, scan_rows, scan_frame_end, evt_ready, ovf_clear,
        input  scan_ready, evt_data, evt_valid, evt_count, overflow, frame_irq
    );

    modport slave (
        input  scan_valid, scan_col, scan_rows, scan_frame_end, evt_ready, ovf_clear,
        output scan_ready, evt_data, evt_valid, evt_count, overflow, frame_irq
    );
endinterface

// File: rtl/kbd_event_queue.sv
// Keyboard event queue: diffs each column snapshot against the stored matrix,
// emits one press/release event per changed row (ascending, one per clock) into
// a first-word-fall-through FIFO, and flags frames that produced events.
module kbd_event_queue #(
    parameter int ROWS  = 9,
    parameter int COLS  = 10,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    kbd_event_queue_if.slave bus
);
    localparam int RW = $clog2(ROWS);
    localparam int AW = $clog2(DEPTH);

    if (COLS * ROWS > 128) begin : g_keycode_width_check
        $error("kbd_event_queue: COLS*ROWS must not exceed 128 (7-bit keycode)");
    end

    typedef enum logic {IDLE, EMIT} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [ROWS-1:0] prev [COLS];
    logic [ROWS-1:0] pend;
    logic [ROWS-1:0] lat_rows;
    logic [3:0]      lat_col;
    logic            lat_fe;
    logic            had_evt;

    logic            accept;
    logic            col_ok;
    logic [ROWS-1:0] prev_sel;
    logic [ROWS-1:0] new_pend;
    logic [RW-1:0]   r_sel;
    logic [ROWS-1:0] pend_clr;
    logic            last;
    logic [6:0]      keycode;
    logic [7:0]      push_data;
    logic            push_try;
    logic            finish_idle;
    logic            finish_emit;

    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   rd_nxt;
    logic [4:0]      count;
    logic [4:0]      count_nxt;
    logic [4:0]      count_after_pop;
    logic [7:0]      head_nxt;
    logic            evt_valid_q;
    logic [7:0]      evt_data_q;
    logic            overflow_q;
    logic            frame_irq_q;
    logic            pop;
    logic            push_ok;
    logic            drop;

    // Index of the lowest set bit; rows are therefore emitted in ascending order.
    function automatic logic [RW-1:0] lowest_bit(input logic [ROWS-1:0] v);
        lowest_bit = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (v[i]) lowest_bit = RW'(i);
        end
    endfunction

    // Snapshot decode: changed bits against the stored column, and the event
    // that the current EMIT cycle produces.
    always_comb begin
        accept   = bus.scan_valid && (state == IDLE);
        col_ok   = bus.scan_col < 4'(COLS);
        prev_sel = '0;
        if (col_ok) prev_sel = prev[bus.scan_col];
        new_pend  = bus.scan_rows ^ prev_sel;
        r_sel     = lowest_bit(pend);
        pend_clr  = pend & ~(ROWS'(1) << r_sel);
        last      = (pend_clr == '0);
        keycode   = 7'(lat_col) * 7'(ROWS) + 7'(r_sel);
        push_data = {lat_rows[r_sel], keycode};
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM next state: leave IDLE only for a valid column with changed bits.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept && col_ok && (new_pend != '0)) state_nxt = EMIT;
            EMIT: if (last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: snapshots are only taken in IDLE, every EMIT cycle pushes.
    always_comb begin
        bus.scan_ready = (state == IDLE);
        push_try       = (state == EMIT);
    end

    // Matrix state is updated on acceptance, even if its events are later dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < COLS; c++) prev[c] <= '0;
        end else if (accept && col_ok) begin
            prev[bus.scan_col] <= bus.scan_rows;
        end
    end

    // Latched snapshot and pending-change mask; stale contents are harmless
    // because they are only consumed in EMIT.
    always_ff @(posedge clk) begin
        if (accept && col_ok) begin
            pend     <= new_pend;
            lat_rows <= bus.scan_rows;
            lat_col  <= bus.scan_col;
            lat_fe   <= bus.scan_frame_end;
        end else if (push_try) begin
            pend <= pend_clr;
        end
    end

    // FIFO control: push admission, pop, and the registered head for fall-through.
    always_comb begin
        pop             = evt_valid_q && bus.evt_ready;
        push_ok         = push_try && ((count < 5'(DEPTH)) || pop);
        drop            = push_try && !push_ok;
        count_after_pop = count - 5'(pop);
        count_nxt       = count_after_pop + 5'(push_ok);
        rd_nxt          = rd_ptr + AW'(pop);
        if (count_after_pop == 5'd0) head_nxt = push_data;
        else                         head_nxt = mem[rd_nxt];
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    // FIFO pointers, occupancy and registered head outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            evt_valid_q <= 1'b0;
            evt_data_q  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr      <= rd_nxt;
            count       <= count_nxt;
            evt_valid_q <= (count_nxt != 5'd0);
            if (count_nxt != 5'd0) evt_data_q <= head_nxt;
        end
    end

    // Frame completion: a frame_end snapshot finishes either on acceptance
    // (nothing to emit) or on its last EMIT cycle.
    always_comb begin
        finish_idle = accept && bus.scan_frame_end && (!col_ok || (new_pend == '0));
        finish_emit = push_try && last && lat_fe;
    end

    // Sticky overflow (a drop beats a same-cycle clear), frame interrupt pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            had_evt     <= 1'b0;
            frame_irq_q <= 1'b0;
        end else begin
            if (drop)               overflow_q <= 1'b1;
            else if (bus.ovf_clear) overflow_q <= 1'b0;
            frame_irq_q <= (finish_idle && had_evt) || finish_emit;
            if (finish_idle || finish_emit) had_evt <= 1'b0;
            else if (push_try)              had_evt <= 1'b1;
        end
    end

    assign bus.evt_valid = evt_valid_q;
    assign bus.evt_data  = evt_data_q;
    assign bus.evt_count = count;
    assign bus.overflow  = overflow_q;
    assign bus.frame_irq = frame_irq_q;
endmodule

// File: tb/tb_kbd_event_queue.sv
// Directed bench for kbd_event_queue: key press/release, multi-row snapshots,
// overflow, full-FIFO push with pop, out-of-range column and async reset.
module tb_kbd_event_queue;
    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   errors  = 0;
    int   irq_seen = 0;

    kbd_event_queue_if #(.ROWS(9)) bus ();

    kbd_event_queue #(.ROWS(9), .COLS(10), .DEPTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.frame_irq === 1'b1) irq_seen <= irq_seen + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d required completion", errors);
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [3:0] col, input logic [8:0] rows, input logic fe);
        int n = 0;
        @(negedge clk);
        while (bus.scan_ready !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (bus.scan_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready: scan_ready=%b required 1", bus.scan_ready);
        end
        bus.scan_valid     = 1'b1;
        bus.scan_col       = col;
        bus.scan_rows      = rows;
        bus.scan_frame_end = fe;
        @(negedge clk);
        bus.scan_valid     = 1'b0;
        bus.scan_frame_end = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.scan_ready !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (bus.scan_ready !== 1'b1) begin
            errors++;
            $display("FAIL wait_idle: scan_ready=%b required 1", bus.scan_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.scan_valid = 1'b0; bus.scan_col = '0; bus.scan_rows = '0;
        bus.scan_frame_end = 1'b0; bus.evt_ready = 1'b0; bus.ovf_clear = 1'b0;
        #1 rst = 1'b1;
        #1;
        vectors++; if (bus.scan_ready !== 1'b1) begin errors++; $display("FAIL rst_scan_ready: got %b want 1", bus.scan_ready); end
        vectors++; if (bus.evt_valid !== 1'b0) begin errors++; $display("FAIL rst_evt_valid: got %b want 0", bus.evt_valid); end
        vectors++; if (bus.evt_data !== 8'h00) begin errors++; $display("FAIL rst_evt_data: got %h want 00", bus.evt_data); end
        vectors++; if (bus.evt_count !== 5'd0) begin errors++; $display("FAIL rst_evt_count: got %0d want 0", bus.evt_count); end
        vectors++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b want 0", bus.overflow); end
        vectors++; if (bus.frame_irq !== 1'b0) begin errors++; $display("FAIL rst_frame_irq: got %b want 0", bus.frame_irq); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_key();
        int base;
        send(4'd8, 9'h008, 1'b0);
        wait_idle();
        vectors++; if (bus.evt_valid !== 1'b1) begin errors++; $display("FAIL press_valid: got %b want 1", bus.evt_valid); end
        vectors++; if (bus.evt_data !== 8'hCB) begin errors++; $display("FAIL press_data: got %h want cb", bus.evt_data); end
        vectors++; if (bus.evt_count !== 5'd1) begin errors++; $display("FAIL press_count: got %0d want 1", bus.evt_count); end
        bus.evt_ready = 1'b1;
        @(negedge clk);
        bus.evt_ready = 1'b0;
        vectors++; if (bus.evt_count !== 5'd0) begin errors++; $display("FAIL press_pop_count: got %0d want 0", bus.evt_count); end
        vectors++; if (bus.evt_valid !== 1'b0) begin errors++; $display("FAIL press_pop_valid: got %b want 0", bus.evt_valid); end
        base = irq_seen;
        send(4'd8, 9'h000, 1'b1);
        wait_idle();
        vectors++; if (bus.evt_data !== 8'h4B) begin errors++; $display("FAIL release_data: got %h want 4b", bus.evt_data); end
        vectors++; if (bus.evt_count !== 5'd1) begin errors++; $display("FAIL release_count: got %0d want 1", bus.evt_count); end
        @(negedge clk);
        vectors++; if (irq_seen - base !== 1) begin errors++; $display("FAIL release_irq: got %0d pulses want 1", irq_seen - base); end
        bus.evt_ready = 1'b1;
        @(negedge clk);
        bus.evt_ready = 1'b0;
    endtask

    task automatic test_two_rows();
        int lows = 0;
        int base;
        send(4'd2, 9'h011, 1'b0);
        while (bus.scan_ready === 1'b0 && lows < 20) begin
            lows++;
            @(negedge clk);
        end
        vectors++; if (lows !== 2) begin errors++; $display("FAIL two_ready_low: got %0d cycles want 2", lows); end
        vectors++; if (bus.evt_count !== 5'd2) begin errors++; $display("FAIL two_count: got %0d want 2", bus.evt_count); end
        vectors++; if (bus.evt_data !== 8'h92) begin errors++; $display("FAIL two_first: got %h want 92", bus.evt_data); end
        bus.evt_ready = 1'b1;
        @(negedge clk);
        bus.evt_ready = 1'b0;
        vectors++; if (bus.evt_data !== 8'h96) begin errors++; $display("FAIL two_second: got %h want 96", bus.evt_data); end
        vectors++; if (bus.evt_count !== 5'd1) begin errors++; $display("FAIL two_count1: got %0d want 1", bus.evt_count); end
        bus.evt_ready = 1'b1;
        @(negedge clk);
        bus.evt_ready = 1'b0;
        base = irq_seen;
        send(4'd2, 9'h011, 1'b0);
        vectors++; if (bus.scan_ready !== 1'b1) begin errors++; $display("FAIL resend_ready: got %b want 1", bus.scan_ready); end
        @(negedge clk);
        @(negedge clk);
        vectors++; if (bus.evt_count !== 5'd0) begin errors++; $display("FAIL resend_count: got %0d want 0", bus.evt_count); end
        vectors++; if (bus.evt_valid !== 1'b0) begin errors++; $display("FAIL resend_valid: got %b want 0", bus.evt_valid); end
        vectors++; if (irq_seen - base !== 0) begin errors++; $display("FAIL resend_irq: got %0d pulses want 0", irq_seen - base); end
    endtask

    task automatic test_overflow();
        send(4'd3, 9'h1FF, 1'b0);
        send(4'd4, 9'h0FF, 1'b0);
        wait_idle();
        vectors++; if (bus.evt_count !== 5'd16) begin errors++; $display("FAIL ovf_count: got %0d want 16", bus.evt_count); end
        vectors++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", bus.overflow); end
        vectors++; if (bus.evt_data !== 8'h9B) begin errors++; $display("FAIL ovf_head: got %h want 9b", bus.evt_data); end
        bus.ovf_clear = 1'b1;
        @(negedge clk);
        bus.ovf_clear = 1'b0;
        vectors++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", bus.overflow); end
    endtask

    task automatic test_full_pop_push();
        logic [7:0] exp;
        send(4'd5, 9'h001, 1'b0);
        bus.evt_ready = 1'b1;
        @(negedge clk);
        bus.evt_ready = 1'b0;
        vectors++; if (bus.evt_count !== 5'd16) begin errors++; $display("FAIL full_count: got %0d want 16", bus.evt_count); end
        vectors++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL full_overflow: got %b want 0", bus.overflow); end
        vectors++; if (bus.scan_ready !== 1'b1) begin errors++; $display("FAIL full_ready: got %b want 1", bus.scan_ready); end
        for (int i = 0; i < 16; i++) begin
            exp = (i < 15) ? 8'(8'h80 + 28 + i) : 8'hAD;
            vectors++;
            if (bus.evt_data !== exp) begin
                errors++;
                $display("FAIL drain_%0d: got %h want %h", i, bus.evt_data, exp);
            end
            bus.evt_ready = 1'b1;
            @(negedge clk);
        end
        bus.evt_ready = 1'b0;
        vectors++; if (bus.evt_count !== 5'd0) begin errors++; $display("FAIL drain_count: got %0d want 0", bus.evt_count); end
        vectors++; if (bus.evt_valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b want 0", bus.evt_valid); end
    endtask

    task automatic test_bad_col();
        int base;
        send(4'd0, 9'h000, 1'b1);
        wait_idle();
        @(negedge clk);
        base = irq_seen;
        send(4'd12, 9'h1FF, 1'b1);
        vectors++; if (bus.scan_ready !== 1'b1) begin errors++; $display("FAIL badcol_ready: got %b want 1", bus.scan_ready); end
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        vectors++; if (irq_seen - base !== 0) begin errors++; $display("FAIL badcol_irq: got %0d pulses want 0", irq_seen - base); end
        vectors++; if (bus.evt_count !== 5'd0) begin errors++; $display("FAIL badcol_count: got %0d want 0", bus.evt_count); end
        send(4'd2, 9'h011, 1'b0);
        @(negedge clk);
        @(negedge clk);
        vectors++; if (bus.evt_count !== 5'd0) begin errors++; $display("FAIL badcol_prev: got %0d events want 0", bus.evt_count); end
    endtask

    task automatic test_reset_mid_emit();
        send(4'd0, 9'h1FF, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        vectors++; if (bus.scan_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %b want 1", bus.scan_ready); end
        vectors++; if (bus.evt_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b want 0", bus.evt_valid); end
        vectors++; if (bus.evt_data !== 8'h00) begin errors++; $display("FAIL mid_rst_data: got %h want 00", bus.evt_data); end
        vectors++; if (bus.evt_count !== 5'd0) begin errors++; $display("FAIL mid_rst_count: got %0d want 0", bus.evt_count); end
        vectors++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL mid_rst_overflow: got %b want 0", bus.overflow); end
        vectors++; if (bus.frame_irq !== 1'b0) begin errors++; $display("FAIL mid_rst_irq: got %b want 0", bus.frame_irq); end
        @(negedge clk);
        rst = 1'b0;
        send(4'd0, 9'h1FF, 1'b0);
        wait_idle();
        vectors++; if (bus.evt_count !== 5'd9) begin errors++; $display("FAIL reemit_count: got %0d want 9", bus.evt_count); end
        vectors++; if (bus.evt_data !== 8'h80) begin errors++; $display("FAIL reemit_head: got %h want 80", bus.evt_data); end
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_two_rows();
        test_overflow();
        test_full_pop_push();
        test_bad_col();
        test_reset_mid_emit();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
